// File: rtl/slow_tick_timer.sv
// Synchronises a divided clock into one-cycle ticks on clk and runs a loadable
// start/stop down-counter on them. Define AUTO_RELOAD_EN to reload on wrap instead of stopping.
module slow_tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [1:0]       fill_q, fill_d;
    logic             armed_q, armed_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] count_q, count_d;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // fill_q marks when s2 holds a real slow_clk sample rather than its reset
    // value, so only a genuine low level can arm the edge detector.
    always_comb begin
        s1_d    = slow_clk;
        s2_d    = s1_q;
        prev_d  = s2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~s2_q);
        tick_d  = s2_q & ~prev_q & armed_q;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wrap_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            count_d  = load_value;
`ifdef AUTO_RELOAD_EN
            reload_d = load_value;
`endif
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start)
                        state_d = (count_q == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick_q) begin
                        if (count_q == WIDTH'(1)) begin
                            wrap_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
                            count_d = reload_q;
`else
                            count_d = '0;
                            state_d = DONE;
`endif
                        end else if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start)
                        state_d = RUN;
                end
                DONE: begin
                    count_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            fill_q   <= 2'b00;
            armed_q  <= 1'b0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            count_q  <= '0;
            state_q  <= IDLE;
`ifdef AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            fill_q   <= fill_d;
            armed_q  <= armed_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            count_q  <= count_d;
            state_q  <= state_d;
`ifdef AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign count   = count_q;
    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);

endmodule

// File: tb/tb_slow_tick_timer.sv
// Bench for slow_tick_timer: directed scenarios plus randomized traffic against a
// sample-history reference model. Follows AUTO_RELOAD_EN when defined.
module tb_slow_tick_timer;

    localparam int W = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         slow_clk = 1'b0;
    logic         start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         tick, running, expired, wrap;
    logic [W-1:0] count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ph = 0;
    int slow_per = 20;
    bit slow_auto = 0;

    // reference model state
    bit           m_samp[$];
    bit           m_tick, m_wrap;
    logic [W-1:0] m_count, m_reload;
    int           m_st;
    int           m_rise = -1;

    slow_tick_timer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .stop(stop),
        .load(load), .load_value(load_value), .tick(tick), .count(count),
        .running(running), .expired(expired), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // A rising edge of slow_clk between two real samples at edges k-1,k shows
    // as tick after edge k+2; the FSM acts on the tick value held before an edge.
    task automatic model_edge();
        bit t_used;
        int k;
        if (reset) begin
            m_samp.delete();
            m_tick = 0; m_wrap = 0; m_count = '0; m_reload = '0; m_st = M_IDLE;
        end else begin
            t_used = m_tick;
            m_samp.push_back(slow_clk);
            k = m_samp.size();
            if (k >= 2 && m_samp[k-1] && !m_samp[k-2]) m_rise = cyc;
            m_tick = (k >= 4) && m_samp[k-3] && !m_samp[k-4];
            m_wrap = 0;
            if (load) begin
                m_count = load_value; m_reload = load_value; m_st = M_IDLE;
            end else if (m_st == M_RUN && stop) begin
                m_st = M_PAUSE;
            end else if (stop) begin
                m_st = m_st;
            end else if (start && m_st == M_IDLE) begin
                m_st = (m_count == 0) ? M_DONE : M_RUN;
            end else if (start && m_st == M_PAUSE) begin
                m_st = M_RUN;
            end else if (m_st == M_RUN && t_used) begin
                if (m_count == 1) begin
                    m_wrap = 1;
`ifdef AUTO_RELOAD_EN
                    m_count = m_reload;
`else
                    m_count = 0;
                    m_st = M_DONE;
`endif
                end else if (m_count != 0) begin
                    m_count = m_count - 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if (slow_auto) begin
            ph++;
            slow_clk = ((ph % slow_per) >= slow_per / 2);
        end
    endtask

    task automatic do_reset(input bit sc);
        reset = 1; slow_clk = sc; load = 0; start = 0; stop = 0; slow_auto = 0;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic start_slow(input int per);
        slow_per = per; ph = 0; slow_clk = 0; slow_auto = 1;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (tick !== 1'b1 && n < 100) begin cycle(); n++; end
        if (n >= 100) begin
            failures++;
            $display("FAIL %s timeout waiting for tick", name);
        end
    endtask

    task automatic test_reset();
        do_reset(0);
        load_value = 16'd7; load = 1; cycle(); load = 0; start = 1; cycle(); start = 0;
        cycle();
        reset = 1; cycle(); reset = 0;
        checks++; if (count !== '0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (tick !== 1'b0)  begin failures++; $display("FAIL reset_tick got=%0d exp=0", tick); end
        checks++; if (wrap !== 1'b0)  begin failures++; $display("FAIL reset_wrap got=%0d exp=0", wrap); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%0d exp=0", running); end
        checks++; if (expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%0d exp=0", expired); end
    endtask

    task automatic test_tick_period();
        int last_tick = -1;
        int ntick = 0;
        bit prev_t = 0;
        do_reset(0);
        start_slow(20);
        repeat (110) begin
            cycle();
            if (tick === 1'b1) begin
                checks++;
                if (cyc - m_rise != 2) begin failures++; $display("FAIL tick_latency got=%0d exp=2", cyc - m_rise); end
                if (last_tick >= 0) begin
                    checks++;
                    if (cyc - last_tick != 20) begin failures++; $display("FAIL tick_spacing got=%0d exp=20", cyc - last_tick); end
                end
                checks++;
                if (prev_t) begin failures++; $display("FAIL tick_width got=2+ exp=1"); end
                last_tick = cyc;
                ntick++;
            end
            prev_t = (tick === 1'b1);
        end
        checks++;
        if (ntick != 5) begin failures++; $display("FAIL tick_count got=%0d exp=5", ntick); end
    endtask

    task automatic test_armed();
        do_reset(1);
        repeat (12) begin
            cycle();
            checks++; if (tick !== 1'b0) begin failures++; $display("FAIL armed_high got=%0d exp=0", tick); end
        end
        slow_clk = 0;
        repeat (3) cycle();
        slow_clk = 1;
        cycle();
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL armed_n got=%0d exp=0", tick); end
        cycle();
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL armed_n1 got=%0d exp=0", tick); end
        cycle();
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL armed_n2 got=%0d exp=1", tick); end
        cycle();
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL armed_n3 got=%0d exp=0", tick); end
    endtask

`ifndef AUTO_RELOAD_EN
    task automatic test_countdown();
        int exp_seq[3] = '{2, 1, 0};
        int idx = 0;
        int wraps = 0;
        int n = 0;
        logic [W-1:0] last;
        do_reset(0);
        start_slow(8);
        load_value = 16'd3; load = 1; cycle(); load = 0;
        start = 1; cycle(); start = 0;
        checks++; if (count !== 16'd3 || running !== 1'b1) begin failures++; $display("FAIL cd_start got=%0d/%0d exp=3/1", count, running); end
        last = count;
        while (expired !== 1'b1 && n < 200) begin
            cycle(); n++;
            if (wrap === 1'b1) begin
                wraps++;
                checks++; if (count !== '0) begin failures++; $display("FAIL cd_wrap_count got=%0d exp=0", count); end
            end
            if (count !== last) begin
                checks++;
                if (idx > 2) begin failures++; $display("FAIL cd_extra_step got=%0d exp=none", count); end
                else if (count !== W'(exp_seq[idx])) begin failures++; $display("FAIL cd_step got=%0d exp=%0d", count, exp_seq[idx]); end
                idx++;
                last = count;
            end
        end
        checks++; if (expired !== 1'b1) begin failures++; $display("FAIL cd_expired got=%0d exp=1", expired); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL cd_running got=%0d exp=0", running); end
        checks++; if (wraps != 1) begin failures++; $display("FAIL cd_wraps got=%0d exp=1", wraps); end
        checks++; if (idx != 3) begin failures++; $display("FAIL cd_steps got=%0d exp=3", idx); end
        start = 1; cycle(); start = 0;
        repeat (10) cycle();
        checks++; if (expired !== 1'b1 || count !== '0) begin failures++; $display("FAIL cd_done_hold got=%0d/%0d exp=1/0", expired, count); end
    endtask
`else
    task automatic test_auto_reload();
        int exp_seq[4] = '{1, 2, 1, 2};
        int idx = 0;
        int wraps = 0;
        int n = 0;
        logic [W-1:0] last;
        do_reset(0);
        start_slow(8);
        load_value = 16'd2; load = 1; cycle(); load = 0;
        start = 1; cycle(); start = 0;
        last = count;
        while (idx < 4 && n < 200) begin
            cycle(); n++;
            checks++; if (running !== 1'b1 || expired !== 1'b0) begin failures++; $display("FAIL ar_state got=%0d/%0d exp=1/0", running, expired); end
            if (wrap === 1'b1) begin
                wraps++;
                checks++; if (count !== 16'd2) begin failures++; $display("FAIL ar_wrap_count got=%0d exp=2", count); end
            end
            if (count !== last) begin
                checks++; if (count !== W'(exp_seq[idx])) begin failures++; $display("FAIL ar_step got=%0d exp=%0d", count, exp_seq[idx]); end
                idx++;
                last = count;
            end
        end
        checks++; if (idx != 4) begin failures++; $display("FAIL ar_steps got=%0d exp=4", idx); end
        checks++; if (wraps != 2) begin failures++; $display("FAIL ar_wraps got=%0d exp=2", wraps); end
    endtask
`endif

    task automatic test_pause();
        do_reset(0);
        start_slow(8);
        load_value = 16'd5; load = 1; cycle(); load = 0;
        start = 1; cycle(); start = 0;
        wait_tick("pause_first_tick");
        checks++; if (count !== 16'd5) begin failures++; $display("FAIL pause_pre got=%0d exp=5", count); end
        stop = 1; cycle(); stop = 0;
        checks++; if (count !== 16'd5) begin failures++; $display("FAIL pause_count got=%0d exp=5", count); end
        checks++; if (running !== 1'b0 || expired !== 1'b0) begin failures++; $display("FAIL pause_state got=%0d/%0d exp=0/0", running, expired); end
        cycle();
        wait_tick("pause_tick1");
        cycle();
        wait_tick("pause_tick2");
        cycle();
        checks++; if (count !== 16'd5) begin failures++; $display("FAIL pause_hold got=%0d exp=5", count); end
        start = 1; cycle(); start = 0;
        checks++; if (running !== 1'b1 || count !== 16'd5) begin failures++; $display("FAIL pause_resume got=%0d/%0d exp=1/5", running, count); end
        wait_tick("pause_resume_tick");
        cycle();
        checks++; if (count !== 16'd4) begin failures++; $display("FAIL pause_dec got=%0d exp=4", count); end
    endtask

    task automatic test_load_zero();
        do_reset(0);
        load_value = 16'd0; load = 1; cycle(); load = 0;
        start = 1; cycle(); start = 0;
        checks++; if (expired !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL lz_state got=%0d/%0d exp=1/0", expired, running); end
        checks++; if (count !== '0) begin failures++; $display("FAIL lz_count got=%0d exp=0", count); end
        start_slow(8);
        load_value = 16'd9; load = 1; cycle(); load = 0;
        start = 1; cycle(); start = 0;
        wait_tick("lz_tick");
        checks++; if (count !== 16'd9 || running !== 1'b1) begin failures++; $display("FAIL lz_run got=%0d/%0d exp=9/1", count, running); end
        load_value = 16'd12; load = 1; cycle(); load = 0;
        checks++; if (count !== 16'd12) begin failures++; $display("FAIL lz_load_tick got=%0d exp=12", count); end
        checks++; if (running !== 1'b0 || expired !== 1'b0) begin failures++; $display("FAIL lz_idle got=%0d/%0d exp=0/0", running, expired); end
    endtask

    task automatic test_random();
        do_reset(0);
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 29) == 0);
            load_value = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            stop  = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) slow_clk = ~slow_clk;
            cycle();
            checks++;
            if (tick !== m_tick || wrap !== m_wrap || count !== m_count ||
                running !== (m_st == M_RUN) || expired !== (m_st == M_DONE)) begin
                failures++;
                if (failures < 20)
                    $display("FAIL rnd_cycle%0d got=t%0d w%0d c%0d r%0d e%0d exp=t%0d w%0d c%0d r%0d e%0d",
                             i, tick, wrap, count, running, expired,
                             m_tick, m_wrap, m_count, (m_st == M_RUN), (m_st == M_DONE));
            end
        end
        reset = 0; load = 0; stop = 0; start = 0;
    endtask

    initial begin
        test_reset();
        test_tick_period();
        test_armed();
`ifndef AUTO_RELOAD_EN
        test_countdown();
`else
        test_auto_reload();
`endif
        test_pause();
        test_load_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
